mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the core's single memory port between instruction fetch (IF) and load/store (D).
//  Sits between the fetch stage / LSU and the memory bus.
//  Registers the grant, holds one outstanding transaction, and routes the ack and read data back to the owner.
//  Supports cancelling an in-flight fetch on a pipeline flush.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  data width; byte enables are DATA_W/8 wide
//  MAX_WAIT  4   consecutive D grants allowed while IF waits (ARB_STARVE_GUARD_EN only); range 1..15
// PORTS
//  i_clk       in   1         clock
//  i_rstn      in   1         reset: synchronous, active-low
//  i_ifReq     in   1         fetch request; hold with i_ifAddr until o_ifAck or flush
//  i_ifAddr    in   ADDR_W    fetch address
//  i_flush     in   1         pipeline flush: cancels pending/outstanding fetch
//  o_ifAck     out  1         1-cycle fetch completion
//  o_ifData    out  DATA_W    fetch data, valid with o_ifAck
//  i_dReq      in   1         LSU request; hold with its operands until o_dAck
//  i_dWe       in   1         1 = store, 0 = load
//  i_dAddr     in   ADDR_W    LSU address
//  i_dWdata    in   DATA_W    store data
//  i_dBe       in   DATA_W/8  byte enables
//  o_dAck      out  1         1-cycle LSU completion
//  o_dRdata    out  DATA_W    load data, valid with o_dAck
//  o_memReq    out  1         bus request; held until i_memAck
//  o_memWe     out  1         bus write enable
//  o_memAddr   out  ADDR_W    bus address (registered)
//  o_memWdata  out  DATA_W    bus write data (registered)
//  o_memBe     out  DATA_W/8  bus byte enables (registered); all ones for fetch
//  i_memAck    in   1         bus completion, any latency >= 0 wait cycles
//  i_memRdata  in   DATA_W    bus read data, valid with i_memAck
//  o_busy      out  1         transaction outstanding (state != IDLE)
// BEHAVIOUR
//  - FSM states: IDLE, FETCH, DATA. o_memReq = o_busy = (state != IDLE).
//  - IDLE, rising edge, arbitration:
//    - i_dReq wins; the FSM latches the D operands and enters DATA.
//    - Otherwise, i_ifReq && !i_flush: the FSM latches i_ifAddr and enters FETCH with memWe=0, memBe=all ones.
//  - Bus outputs come from registers, so o_memReq rises 1 cycle after the request is sampled.
//  - FETCH/DATA: on i_memAck the owner's ack is driven combinationally in that cycle and i_memRdata is passed through.
//    The next state is IDLE.
//  - Min turnaround: 1 IDLE cycle between transactions. Zero-wait bus gives 1 transaction per 2 cycles.
//  - A requester keeping req high after its ack starts a new transaction at the next IDLE arbitration.
//  - Flush:
//    - i_flush in FETCH sets the dropFlag register. The bus transaction still completes, because the bus cannot abort.
//    - o_ifAck is suppressed on that ack. dropFlag clears on the ack cycle.
//    - i_flush has no effect on DATA.
//  - i_memAck while IDLE is ignored. o_ifAck and o_dAck are never both high.
//  - o_ifData and o_dRdata = i_memRdata when their ack is high, else 0.
//  - Reset (i_rstn low at edge, including mid-transaction):
//    - state = IDLE; o_memReq, o_busy, o_ifAck, o_dAck = 0.
//    - memAddr, memWdata, memBe, memWe and dropFlag = 0.
//    - starvation counter = 0.
//    - A late i_memAck after reset is ignored.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined:
//   - A 4-bit counter increments on each D grant made while i_ifReq is high.
//   - The counter clears on any IF grant, or when i_ifReq is low at an arbitration.
//   - When count == MAX_WAIT and i_ifReq && !i_flush, IF wins the next arbitration over D.
//  ARB_STARVE_GUARD_EN undefined: strict D priority, no counter; IF can starve.
// TESTING
//  1 i_rstn=0 for 2 cycles, all reqs=1 -> memReq/busy/acks=0; the first grant follows 1 cycle after release.
//  2 ifReq, addr=0x100; memAck after 2 wait cycles, rdata=0x00000013
//    -> memAddr=0x100, memBe=0xF, memWe=0; o_ifAck pulses in the memAck cycle with 0x13.
//  3 ifReq(0x100) and dReq store(0x2000, 0xDEADBEEF, be=0xF) in the same cycle
//    -> DATA first with memWe=1; after 1 IDLE cycle, FETCH of 0x100.
//  4 MAX_WAIT=4, dReq and ifReq held high, zero-wait bus
//    -> with the macro, grants are D,D,D,D,IF; without it, IF is never granted until dReq drops.
//  5 i_flush pulsed mid-FETCH, ack later -> o_ifAck stays 0; next fetch of 0x200 completes normally.
//  6 i_rstn low during DATA with memAck still pending -> IDLE next cycle, no o_dAck; a late memAck is ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the core's single memory port between instruction fetch (IF) and
//   load/store (D). One transaction is outstanding at a time. The bus request
//   and its operands come from registers. The owner's ack and read data are
//   routed back combinationally in the cycle the bus acknowledges. A pipeline
//   flush cancels a pending fetch. It also drops the ack of a fetch already on
//   the bus.
//
//   Optional feature macro: ARB_STARVE_GUARD_EN
//     defined   : after MAX_WAIT consecutive D grants made while IF waits, IF
//                 wins the next arbitration.
//     undefined : strict D priority, so IF can starve.
//
// Parameters
//   ADDR_W    address width
//   DATA_W    data width (byte enables are DATA_W/8 wide)
//   MAX_WAIT  D grants tolerated while IF waits (guard build only), 1..15
//
// Ports
//   i_clk, i_rstn                     clock, synchronous active-low reset
//   i_ifReq/i_ifAddr/i_flush          fetch request side
//   o_ifAck/o_ifData                  fetch completion + data
//   i_dReq/i_dWe/i_dAddr/i_dWdata/i_dBe  LSU request side
//   o_dAck/o_dRdata                   LSU completion + load data
//   o_memReq/o_memWe/o_memAddr/o_memWdata/o_memBe  bus request (registered)
//   i_memAck/i_memRdata               bus completion + read data
//   o_busy                            transaction outstanding
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_ifReq,
  input  logic [ADDR_W-1:0]     i_ifAddr,
  input  logic                  i_flush,
  output logic                  o_ifAck,
  output logic [DATA_W-1:0]     o_ifData,
  input  logic                  i_dReq,
  input  logic                  i_dWe,
  input  logic [ADDR_W-1:0]     i_dAddr,
  input  logic [DATA_W-1:0]     i_dWdata,
  input  logic [DATA_W/8-1:0]   i_dBe,
  output logic                  o_dAck,
  output logic [DATA_W-1:0]     o_dRdata,
  output logic                  o_memReq,
  output logic                  o_memWe,
  output logic [ADDR_W-1:0]     o_memAddr,
  output logic [DATA_W-1:0]     o_memWdata,
  output logic [DATA_W/8-1:0]   o_memBe,
  input  logic                  i_memAck,
  input  logic [DATA_W-1:0]     i_memRdata,
  output logic                  o_busy
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;

  // The starvation counter is 4 bits wide, so MAX_WAIT must fit in it.
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("mem_port_arbiter: MAX_WAIT out of range 1..15");
  end

  logic [1:0]        state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              drop_q, drop_d;
  logic              if_ack_s;
  logic              d_ack_s;
  logic              if_forced_s;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  logic [3:0] starve_cnt_q, starve_cnt_d;

  // IF overrides D priority once D has been granted MAX_WAIT times in a row.
  assign if_forced_s = (starve_cnt_q == MAX_WAIT_C) && i_ifReq && !i_flush;

  // Starvation counter next-state. The count only moves on IDLE-cycle
  // arbitration. It saturates at MAX_WAIT so that the override stays armed
  // while IF is held off, for example by a flush.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == S_IDLE) begin
      if (!i_ifReq) begin
        starve_cnt_d = 4'd0;
      end else if (i_dReq && !if_forced_s) begin
        if (starve_cnt_q >= MAX_WAIT_C) begin
          starve_cnt_d = starve_cnt_q;
        end else begin
          starve_cnt_d = starve_cnt_q + 4'd1;
        end
      end else if (!i_flush) begin
        starve_cnt_d = 4'd0;
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign if_forced_s = 1'b0;
`endif

  // Arbitration, transaction tracking and ack routing.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    drop_d      = drop_q;
    if_ack_s    = 1'b0;
    d_ack_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (i_dReq && !if_forced_s) begin
          state_d     = S_DATA;
          mem_we_d    = i_dWe;
          mem_addr_d  = i_dAddr;
          mem_wdata_d = i_dWdata;
          mem_be_d    = i_dBe;
        end else if (i_ifReq && !i_flush) begin
          state_d     = S_FETCH;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_ifAddr;
          mem_wdata_d = {DATA_W{1'b0}};
          mem_be_d    = {BE_W{1'b1}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (i_memAck) begin
          // The bus cannot abort a fetch. A flush that arrives before or with
          // the ack only hides the completion from the fetch stage.
          if_ack_s = !(drop_q || i_flush);
          state_d  = S_IDLE;
          drop_d   = 1'b0;
        end else if (i_flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      S_DATA: begin
        if (i_memAck) begin
          d_ack_s = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
        end
      end
      default: begin
        state_d = S_IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  // State and bus-side registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_be_q    <= {BE_W{1'b0}};
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      drop_q      <= drop_d;
    end
  end

  assign o_memReq   = (state_q != S_IDLE);
  assign o_busy     = (state_q != S_IDLE);
  assign o_memWe    = mem_we_q;
  assign o_memAddr  = mem_addr_q;
  assign o_memWdata = mem_wdata_q;
  assign o_memBe    = mem_be_q;
  assign o_ifAck    = if_ack_s;
  assign o_dAck     = d_ack_s;
  assign o_ifData   = if_ack_s ? i_memRdata : {DATA_W{1'b0}};
  assign o_dRdata   = d_ack_s  ? i_memRdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed scenarios followed by a randomized phase. Each cycle, every DUT
//   output is compared with a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int MAXW = 4;

  logic        i_clk;
  logic        i_rstn;
  logic        i_ifReq;
  logic [31:0] i_ifAddr;
  logic        i_flush;
  logic        o_ifAck;
  logic [31:0] o_ifData;
  logic        i_dReq;
  logic        i_dWe;
  logic [31:0] i_dAddr;
  logic [31:0] i_dWdata;
  logic [3:0]  i_dBe;
  logic        o_dAck;
  logic [31:0] o_dRdata;
  logic        o_memReq;
  logic        o_memWe;
  logic [31:0] o_memAddr;
  logic [31:0] o_memWdata;
  logic [3:0]  o_memBe;
  logic        i_memAck;
  logic [31:0] i_memRdata;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_ifReq(i_ifReq), .i_ifAddr(i_ifAddr), .i_flush(i_flush),
    .o_ifAck(o_ifAck), .o_ifData(o_ifData),
    .i_dReq(i_dReq), .i_dWe(i_dWe), .i_dAddr(i_dAddr), .i_dWdata(i_dWdata),
    .i_dBe(i_dBe), .o_dAck(o_dAck), .o_dRdata(o_dRdata),
    .o_memReq(o_memReq), .o_memWe(o_memWe), .o_memAddr(o_memAddr),
    .o_memWdata(o_memWdata), .o_memBe(o_memBe),
    .i_memAck(i_memAck), .i_memRdata(i_memRdata), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: who owns the bus (0 none, 1 fetch, 2 LSU), the request
  // presented on the bus, whether a fetch result is to be dropped, and how
  // many D grants IF has waited through.
  int          m_owner;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_drop;
  int          m_cnt;
  logic        last_if_ack;
  logic        last_d_ack;
  logic        last_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
    m_be = 4'h0; m_drop = 1'b0; m_cnt = 0;
  endtask

  // Winner of an arbitration held in an idle cycle: 0 none, 1 fetch, 2 LSU.
  function automatic int pick_winner();
    bit if_ok;
    if_ok = i_ifReq && !i_flush;
`ifdef ARB_STARVE_GUARD_EN
    if (if_ok && m_cnt == MAXW) return 1;
`endif
    if (i_dReq) return 2;
    if (if_ok) return 1;
    return 0;
  endfunction

  task automatic check_outputs();
    logic busy_e, if_ack_e, d_ack_e;
    busy_e   = (m_owner != 0);
    if_ack_e = (m_owner == 1) && i_memAck && !m_drop && !i_flush;
    d_ack_e  = (m_owner == 2) && i_memAck;
    chk("mem_req",   {31'd0, o_memReq}, {31'd0, busy_e});
    chk("busy",      {31'd0, o_busy},   {31'd0, busy_e});
    chk("mem_we",    {31'd0, o_memWe},  {31'd0, m_we});
    chk("mem_addr",  o_memAddr,  m_addr);
    chk("mem_wdata", o_memWdata, m_wdata);
    chk("mem_be",    {28'd0, o_memBe}, {28'd0, m_be});
    chk("if_ack",    {31'd0, o_ifAck}, {31'd0, if_ack_e});
    chk("if_data",   o_ifData, if_ack_e ? i_memRdata : 32'h0);
    chk("d_ack",     {31'd0, o_dAck},  {31'd0, d_ack_e});
    chk("d_rdata",   o_dRdata, d_ack_e ? i_memRdata : 32'h0);
    last_if_ack = if_ack_e;
    last_d_ack  = d_ack_e;
    last_flush  = i_flush;
  endtask

  task automatic model_advance();
    int w;
    if (!i_rstn) begin
      model_reset();
    end else if (m_owner == 0) begin
      w = pick_winner();
      if (w == 2) begin
        m_owner = 2; m_we = i_dWe; m_addr = i_dAddr; m_wdata = i_dWdata; m_be = i_dBe;
        if (i_ifReq) m_cnt = (m_cnt + 1 > MAXW) ? MAXW : m_cnt + 1;
        else m_cnt = 0;
      end else if (w == 1) begin
        m_owner = 1; m_we = 1'b0; m_addr = i_ifAddr; m_wdata = 32'h0; m_be = 4'hF;
        m_cnt = 0;
      end else if (!i_ifReq) begin
        m_cnt = 0;
      end
      m_drop = 1'b0;
    end else if (m_owner == 1) begin
      if (i_memAck) begin m_owner = 0; m_drop = 1'b0; end
      else if (i_flush) m_drop = 1'b1;
    end else begin
      if (i_memAck) m_owner = 0;
    end
  endtask

  // One clock: check outputs against the model, advance the model, and return
  // at the next falling edge, ready for the next input changes.
  task automatic cycle();
    #1;
    check_outputs();
    model_advance();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  logic exp_we [5];

  initial begin
    // Test 1: reset with every request asserted.
    i_rstn = 1'b0; i_ifReq = 1'b1; i_ifAddr = 32'h100; i_flush = 1'b0;
    i_dReq = 1'b1; i_dWe = 1'b1; i_dAddr = 32'h2000; i_dWdata = 32'h1234_5678;
    i_dBe = 4'hF; i_memAck = 1'b0; i_memRdata = 32'h0;
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    cycle();
    cycle();
    i_rstn = 1'b1;
    cycle();
    chk("t1_first_grant", {31'd0, o_busy}, 32'd1);
    i_dReq = 1'b0; i_ifReq = 1'b0; i_memAck = 1'b1; i_memRdata = 32'hA5A5_0000;
    cycle();
    i_memAck = 1'b0;
    cycle();

    // Test 2: fetch with two wait cycles.
    i_ifReq = 1'b1; i_ifAddr = 32'h100;
    cycle();
    chk("t2_addr", o_memAddr, 32'h100);
    chk("t2_be", {28'd0, o_memBe}, 32'hF);
    chk("t2_we", {31'd0, o_memWe}, 32'd0);
    cycle();
    cycle();
    i_memAck = 1'b1; i_memRdata = 32'h0000_0013;
    #1;
    chk("t2_ifack", {31'd0, o_ifAck}, 32'd1);
    chk("t2_ifdata", o_ifData, 32'h13);
    cycle();
    i_ifReq = 1'b0; i_memAck = 1'b0;
    cycle();

    // Test 3: simultaneous fetch and store requests; the store goes first.
    i_ifReq = 1'b1; i_ifAddr = 32'h100;
    i_dReq = 1'b1; i_dWe = 1'b1; i_dAddr = 32'h2000; i_dWdata = 32'hDEAD_BEEF; i_dBe = 4'hF;
    cycle();
    chk("t3_d_first_we", {31'd0, o_memWe}, 32'd1);
    chk("t3_d_addr", o_memAddr, 32'h2000);
    chk("t3_d_wdata", o_memWdata, 32'hDEAD_BEEF);
    i_memAck = 1'b1;
    cycle();
    i_dReq = 1'b0; i_memAck = 1'b0;
    #1;
    chk("t3_idle_gap", {31'd0, o_busy}, 32'd0);
    cycle();
    chk("t3_fetch_addr", o_memAddr, 32'h100);
    chk("t3_fetch_we", {31'd0, o_memWe}, 32'd0);
    i_memAck = 1'b1; i_memRdata = 32'h0000_0777;
    cycle();
    i_ifReq = 1'b0; i_memAck = 1'b0;
    cycle();

    // Test 4: both requests held high on a zero-wait bus.
    i_rstn = 1'b0;
    cycle();
    i_rstn = 1'b1;
`ifdef ARB_STARVE_GUARD_EN
    exp_we[0] = 1'b1; exp_we[1] = 1'b1; exp_we[2] = 1'b1; exp_we[3] = 1'b1; exp_we[4] = 1'b0;
`else
    exp_we[0] = 1'b1; exp_we[1] = 1'b1; exp_we[2] = 1'b1; exp_we[3] = 1'b1; exp_we[4] = 1'b1;
`endif
    i_dReq = 1'b1; i_dWe = 1'b1; i_dAddr = 32'h3000; i_dWdata = 32'h0BAD_F00D; i_dBe = 4'h3;
    i_ifReq = 1'b1; i_ifAddr = 32'h400; i_memAck = 1'b1; i_memRdata = 32'h55;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t4_grant_we", {31'd0, o_memWe}, {31'd0, exp_we[k]});
      cycle();
    end
    i_dReq = 1'b0;
    cycle();
    chk("t4_if_after_d_drop", {31'd0, o_memWe}, 32'd0);
    chk("t4_if_addr", o_memAddr, 32'h400);
    cycle();
    i_ifReq = 1'b0; i_memAck = 1'b0;
    cycle();

    // Test 5: flush in the middle of a fetch, then a normal fetch.
    i_ifReq = 1'b1; i_ifAddr = 32'h180;
    cycle();
    cycle();
    i_flush = 1'b1; i_ifReq = 1'b0;
    cycle();
    i_flush = 1'b0;
    cycle();
    i_memAck = 1'b1; i_memRdata = 32'hCAFE_0001;
    #1;
    chk("t5_flushed_ack", {31'd0, o_ifAck}, 32'd0);
    cycle();
    i_memAck = 1'b0; i_ifReq = 1'b1; i_ifAddr = 32'h200;
    cycle();
    chk("t5_next_addr", o_memAddr, 32'h200);
    i_memAck = 1'b1; i_memRdata = 32'hCAFE_0002;
    #1;
    chk("t5_next_ack", {31'd0, o_ifAck}, 32'd1);
    cycle();
    i_ifReq = 1'b0; i_memAck = 1'b0;
    cycle();

    // Test 6: reset during a load, then a late bus ack.
    i_dReq = 1'b1; i_dWe = 1'b0; i_dAddr = 32'h5000; i_dBe = 4'hF;
    cycle();
    i_rstn = 1'b0;
    cycle();
    i_rstn = 1'b1; i_dReq = 1'b0; i_memAck = 1'b1; i_memRdata = 32'h7777_7777;
    #1;
    chk("t6_busy_after_rst", {31'd0, o_busy}, 32'd0);
    chk("t6_late_ack", {31'd0, o_dAck}, 32'd0);
    chk("t6_addr_cleared", o_memAddr, 32'h0);
    cycle();
    i_memAck = 1'b0;
    cycle();

    // Randomized phase. The requesters follow the handshake, and the bus acks
    // at random, including while the arbiter is idle.
    for (int c = 0; c < 3000; c++) begin
      if (i_ifReq && (last_if_ack || last_flush)) i_ifReq = 1'b0;
      if (i_dReq && last_d_ack) i_dReq = 1'b0;
      if (!i_ifReq && ($urandom % 3 == 0)) begin
        i_ifReq = 1'b1;
        i_ifAddr = $urandom & 32'hFFFF_FFFC;
      end
      if (!i_dReq && ($urandom % 3 == 0)) begin
        i_dReq = 1'b1;
        i_dWe = 1'($urandom % 2);
        i_dAddr = $urandom;
        i_dWdata = $urandom;
        i_dBe = 4'($urandom % 16);
      end
      i_flush = ($urandom % 16 == 0);
      i_memAck = ($urandom % 5 < 2);
      i_memRdata = $urandom;
      i_rstn = ($urandom % 200 != 0);
      cycle();
      chk("excl_acks", {31'd0, o_ifAck & o_dAck}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
